// File: rtl/fx3_wr_scheduler.sv
// fx3_wr_scheduler: arbitrates two 32-bit streaming sources onto the single
// FX3 slave-FIFO write port. Whole DMA bursts are granted round-robin, each
// gated by the target socket's ready flag. A burst cut short by a stalled
// source or by streaming being disabled is committed with a PKTEND pulse.
// BURST_LEN must be at least 2. ADDR_SETTLE, GAP_CYCLES and IDLE_TIMEOUT must
// each be at least 1.
module fx3_wr_scheduler #(
    parameter int BURST_LEN    = 1024,
    parameter int ADDR_SETTLE  = 3,
    parameter int IDLE_TIMEOUT = 64,
    parameter int GAP_CYCLES   = 3
) (
    input  logic        clk_100,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] ch0_data,
    input  logic [31:0] ch1_data,
    input  logic        ch0_valid,
    input  logic        ch1_valid,
    output logic        ch0_ready,
    output logic        ch1_ready,
    input  logic        dma_rdy0,
    input  logic        dma_rdy1,
    output logic [1:0]  faddr,
    output logic [31:0] fdata,
    output logic        slwr_n,
    output logic        pktend_n,
    output logic        slcs_n,
    output logic        grant,
    output logic        busy
);

    localparam int WL_W    = $clog2(BURST_LEN) + 1;
    localparam int ST_W    = $clog2(IDLE_TIMEOUT + 1);
    localparam int CNT_MAX = (ADDR_SETTLE > GAP_CYCLES) ? ADDR_SETTLE : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CHECK,
        S_BURST,
        S_PKTEND,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              lastGrant_q, lastGrant_d;
    logic [1:0]        faddr_q, faddr_d;
    logic [31:0]       fdata_q, fdata_d;
    logic              slwr_n_q, slwr_n_d;
    logic              pktend_n_q, pktend_n_d;
    logic              slcs_n_q, slcs_n_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WL_W-1:0]   wordsLeft_q, wordsLeft_d;
    logic [ST_W-1:0]   stallCnt_q, stallCnt_d;

    logic              selValid;
    logic [31:0]       selData;
    logic              selDmaRdy;
    logic              burstReady;
    logic              xfer;
    logic              elig0;
    logic              elig1;
    logic              pick;
    logic              anyWritten;
    logic [ST_W-1:0]   stallInc;

    // Steer the granted channel's handshake, data and socket flag into one path.
    always_comb begin
        selValid   = grant_q ? ch1_valid : ch0_valid;
        selData    = grant_q ? ch1_data  : ch0_data;
        selDmaRdy  = grant_q ? dma_rdy1  : dma_rdy0;
        burstReady = (state_q == S_BURST) && (wordsLeft_q != '0) && enable;
        xfer       = burstReady && selValid;
        ch0_ready  = burstReady && !grant_q;
        ch1_ready  = burstReady && grant_q;
        elig0      = enable && ch0_valid;
        elig1      = enable && ch1_valid;
        pick       = (elig0 && elig1) ? !lastGrant_q : elig1;
        anyWritten = (wordsLeft_q != WL_W'(BURST_LEN));
        stallInc   = (stallCnt_q == ST_W'(IDLE_TIMEOUT)) ? stallCnt_q
                                                         : stallCnt_q + ST_W'(1);
    end

    // Next-state and next-output logic for the arbitration / burst sequencer.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        faddr_d     = faddr_q;
        fdata_d     = fdata_q;
        slwr_n_d    = 1'b1;
        pktend_n_d  = 1'b1;
        cnt_d       = cnt_q;
        wordsLeft_d = wordsLeft_q;
        stallCnt_d  = stallCnt_q;

        case (state_q)
            S_IDLE: begin
                if (elig0 || elig1) begin
                    grant_d = pick;
                    faddr_d = {1'b0, pick};
                    cnt_d   = CNT_W'(ADDR_SETTLE);
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_CHECK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CHECK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (selDmaRdy) begin
                    wordsLeft_d = WL_W'(BURST_LEN);
                    stallCnt_d  = '0;
                    state_d     = S_BURST;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BURST: begin
                if (xfer) begin
                    fdata_d     = selData;
                    slwr_n_d    = 1'b0;
                    wordsLeft_d = wordsLeft_q - WL_W'(1);
                    stallCnt_d  = '0;
                    if (wordsLeft_q == WL_W'(1)) begin
                        lastGrant_d = grant_q;
                        cnt_d       = CNT_W'(GAP_CYCLES);
                        state_d     = S_GAP;
                    end
                end else begin
                    stallCnt_d = stallInc;
                    if (!enable || (stallInc == ST_W'(IDLE_TIMEOUT))) begin
                        lastGrant_d = grant_q;
                        if (anyWritten) begin
                            pktend_n_d = 1'b0;
                            state_d    = S_PKTEND;
                        end else begin
                            cnt_d   = CNT_W'(GAP_CYCLES);
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_PKTEND: begin
                cnt_d   = CNT_W'(GAP_CYCLES);
                state_d = S_GAP;
            end
            S_GAP: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        slcs_n_d = (state_d == S_IDLE);
        busy_d   = (state_d != S_IDLE);
    end

    // State, counters and registered FX3 pad outputs with synchronous reset.
    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q     <= S_IDLE;
            grant_q     <= 1'b0;
            lastGrant_q <= 1'b1;
            faddr_q     <= 2'b00;
            fdata_q     <= '0;
            slwr_n_q    <= 1'b1;
            pktend_n_q  <= 1'b1;
            slcs_n_q    <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            wordsLeft_q <= '0;
            stallCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            faddr_q     <= faddr_d;
            fdata_q     <= fdata_d;
            slwr_n_q    <= slwr_n_d;
            pktend_n_q  <= pktend_n_d;
            slcs_n_q    <= slcs_n_d;
            busy_q      <= busy_d;
            cnt_q       <= cnt_d;
            wordsLeft_q <= wordsLeft_d;
            stallCnt_q  <= stallCnt_d;
        end
    end

    assign faddr    = faddr_q;
    assign fdata    = fdata_q;
    assign slwr_n   = slwr_n_q;
    assign pktend_n = pktend_n_q;
    assign slcs_n   = slcs_n_q;
    assign grant    = grant_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_fx3_wr_scheduler.sv
// Directed testbench for fx3_wr_scheduler: reset, full bursts, round-robin,
// socket-not-ready retry, short packets by stall and by disable, mid-burst reset.
module tb_fx3_wr_scheduler;

    localparam logic [31:0] BASE0 = 32'hA000_0000;
    localparam logic [31:0] BASE1 = 32'hB100_0000;

    logic        clk_100 = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] ch0_data;
    logic [31:0] ch1_data;
    logic        ch0_valid;
    logic        ch1_valid;
    logic        ch0_ready;
    logic        ch1_ready;
    logic        dma_rdy0;
    logic        dma_rdy1;
    logic [1:0]  faddr;
    logic [31:0] fdata;
    logic        slwr_n;
    logic        pktend_n;
    logic        slcs_n;
    logic        grant;
    logic        busy;

    int testsRun    = 0;
    int testsFailed = 0;
    int idx0;
    int idx1;
    logic acc0;
    logic acc1;

    fx3_wr_scheduler dut (
        .clk_100   (clk_100),
        .reset     (reset),
        .enable    (enable),
        .ch0_data  (ch0_data),
        .ch1_data  (ch1_data),
        .ch0_valid (ch0_valid),
        .ch1_valid (ch1_valid),
        .ch0_ready (ch0_ready),
        .ch1_ready (ch1_ready),
        .dma_rdy0  (dma_rdy0),
        .dma_rdy1  (dma_rdy1),
        .faddr     (faddr),
        .fdata     (fdata),
        .slwr_n    (slwr_n),
        .pktend_n  (pktend_n),
        .slcs_n    (slcs_n),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk_100 = ~clk_100;

    // One clock: note handshakes at the falling edge, advance the sources after the rising edge.
    task automatic tick();
        @(negedge clk_100);
        acc0 = ch0_valid & ch0_ready;
        acc1 = ch1_valid & ch1_ready;
        @(posedge clk_100);
        #1;
        if (acc0) idx0++;
        if (acc1) idx1++;
        ch0_data = BASE0 | 32'(idx0);
        ch1_data = BASE1 | 32'(idx1);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        ch0_valid = 1'b0;
        ch1_valid = 1'b0;
        dma_rdy0  = 1'b0;
        dma_rdy1  = 1'b0;
        idx0      = 0;
        idx1      = 0;
        ch0_data  = BASE0;
        ch1_data  = BASE1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int limit, output int n);
        n = 0;
        while (busy !== lvl && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        while (slwr_n !== 1'b0 && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic run_until_idle(input int limit, output int strobes, output int pkts, output int cyc);
        strobes = 0;
        pkts    = 0;
        cyc     = 0;
        while (busy === 1'b1 && cyc < limit) begin
            if (slwr_n === 1'b0) strobes++;
            if (pktend_n === 1'b0) pkts++;
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        testsRun++;
        if ({faddr, fdata, slwr_n, pktend_n, slcs_n} !== {2'b00, 32'h0, 1'b1, 1'b1, 1'b1}) begin
            testsFailed++;
            $display("[TB] FAIL reset_pads: got faddr=%b fdata=%h slwr_n=%b pktend_n=%b slcs_n=%b expected 00 00000000 1 1 1",
                     faddr, fdata, slwr_n, pktend_n, slcs_n);
        end
        testsRun++;
        if ({grant, busy, ch0_ready, ch1_ready} !== 4'b0000) begin
            testsFailed++;
            $display("[TB] FAIL reset_status: got grant=%b busy=%b rdy0=%b rdy1=%b expected all 0",
                     grant, busy, ch0_ready, ch1_ready);
        end
    endtask

    task automatic test_stream_ch0();
        int n;
        int s;
        int m;
        int pk;
        do_reset();
        enable    = 1'b1;
        ch0_valid = 1'b1;
        dma_rdy0  = 1'b1;
        wait_busy(1'b1, 10, n);
        testsRun++;
        if (busy !== 1'b1 || grant !== 1'b0 || faddr !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL stream_grant: got busy=%b grant=%b faddr=%b expected 1 0 00", busy, grant, faddr);
        end
        wait_strobe(20, n);
        testsRun++;
        if (n !== 5) begin
            testsFailed++;
            $display("[TB] FAIL stream_first_strobe: got %0d cycles expected 5", n);
        end
        s  = 1;
        pk = 0;
        while (s < 2000) begin
            tick();
            if (pktend_n === 1'b0) pk++;
            if (slwr_n === 1'b0) s++;
            else break;
        end
        testsRun++;
        if (s !== 1024 || pk !== 0) begin
            testsFailed++;
            $display("[TB] FAIL stream_burst_len: got %0d strobes %0d pktend expected 1024 0", s, pk);
        end
        m = 1;
        while (busy !== 1'b0 && m < 10) begin
            tick();
            m++;
        end
        testsRun++;
        if (m !== 3) begin
            testsFailed++;
            $display("[TB] FAIL stream_gap: got idle after %0d cycles expected 3", m);
        end
        tick();
        testsRun++;
        if (busy !== 1'b1 || grant !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL stream_regrant: got busy=%b grant=%b expected 1 0", busy, grant);
        end
        wait_strobe(20, n);
        testsRun++;
        if (n !== 5 || fdata !== (BASE0 | 32'd1024)) begin
            testsFailed++;
            $display("[TB] FAIL stream_second_burst: got %0d cycles fdata=%h expected 5 %h", n, fdata, BASE0 | 32'd1024);
        end
    endtask

    task automatic test_round_robin();
        int n;
        int c;
        int strobes;
        int leak;
        logic exp;
        logic [31:0] firstWord;
        logic [31:0] expWord;
        do_reset();
        enable    = 1'b1;
        ch0_valid = 1'b1;
        ch1_valid = 1'b1;
        dma_rdy0  = 1'b1;
        dma_rdy1  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            exp = (b == 1);
            wait_busy(1'b1, 20, n);
            testsRun++;
            if (busy !== 1'b1 || grant !== exp || faddr !== {1'b0, exp}) begin
                testsFailed++;
                $display("[TB] FAIL rr_grant_%0d: got busy=%b grant=%b faddr=%b expected 1 %b 0%b",
                         b, busy, grant, faddr, exp, exp);
            end
            strobes   = 0;
            leak      = 0;
            c         = 0;
            firstWord = 32'h0;
            while (busy === 1'b1 && c < 1200) begin
                if ((exp ? ch0_ready : ch1_ready) !== 1'b0) leak++;
                if (slwr_n === 1'b0) begin
                    if (strobes == 0) firstWord = fdata;
                    strobes++;
                end
                tick();
                c++;
            end
            expWord = (exp ? BASE1 : BASE0) | ((b == 2) ? 32'd1024 : 32'd0);
            testsRun++;
            if (strobes !== 1024 || leak !== 0 || firstWord !== expWord) begin
                testsFailed++;
                $display("[TB] FAIL rr_burst_%0d: got strobes=%0d leak=%0d first=%h expected 1024 0 %h",
                         b, strobes, leak, firstWord, expWord);
            end
        end
    endtask

    task automatic test_socket_not_ready();
        int n;
        int strobes;
        int pkts;
        int cyc;
        do_reset();
        enable    = 1'b1;
        ch1_valid = 1'b1;
        wait_busy(1'b1, 10, n);
        testsRun++;
        if (busy !== 1'b1 || grant !== 1'b1 || faddr !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL nrdy_grant_ch1: got busy=%b grant=%b faddr=%b expected 1 1 01", busy, grant, faddr);
        end
        run_until_idle(20, strobes, pkts, cyc);
        testsRun++;
        if (strobes !== 0 || pkts !== 0 || cyc !== 4) begin
            testsFailed++;
            $display("[TB] FAIL nrdy_abort: got strobes=%0d pkts=%0d cycles=%0d expected 0 0 4", strobes, pkts, cyc);
        end
        ch0_valid = 1'b1;
        wait_busy(1'b1, 5, n);
        testsRun++;
        if (busy !== 1'b1 || grant !== 1'b0 || faddr !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL nrdy_grant_ch0: got busy=%b grant=%b faddr=%b expected 1 0 00", busy, grant, faddr);
        end
        ch0_valid = 1'b0;
        dma_rdy1  = 1'b1;
        run_until_idle(20, strobes, pkts, cyc);
        wait_busy(1'b1, 5, n);
        testsRun++;
        if (busy !== 1'b1 || grant !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL nrdy_regrant_ch1: got busy=%b grant=%b expected 1 1", busy, grant);
        end
        wait_strobe(10, n);
        testsRun++;
        if (n !== 5 || slwr_n !== 1'b0 || fdata !== BASE1) begin
            testsFailed++;
            $display("[TB] FAIL nrdy_ch1_write: got %0d cycles slwr_n=%b fdata=%h expected 5 0 %h", n, slwr_n, fdata, BASE1);
        end
    endtask

    task automatic test_short_packet();
        int n;
        int c;
        int strobes;
        int last;
        int pktAt;
        int pkts;
        int overlap;
        do_reset();
        enable    = 1'b1;
        ch0_valid = 1'b1;
        dma_rdy0  = 1'b1;
        wait_busy(1'b1, 10, n);
        c = 0; strobes = 0; last = -1; pktAt = -1; pkts = 0; overlap = 0;
        while (busy === 1'b1 && c < 400) begin
            if (slwr_n === 1'b0) begin
                testsRun++;
                if (fdata !== (BASE0 | 32'(strobes))) begin
                    testsFailed++;
                    $display("[TB] FAIL short_fdata_%0d: got %h expected %h", strobes, fdata, BASE0 | 32'(strobes));
                end
                strobes++;
                last = c;
            end
            if (pktend_n === 1'b0) begin
                pkts++;
                pktAt = c;
                if (slwr_n === 1'b0) overlap++;
            end
            tick();
            c++;
            if (idx0 >= 100) ch0_valid = 1'b0;
        end
        testsRun++;
        if (strobes !== 100 || pkts !== 1 || overlap !== 0) begin
            testsFailed++;
            $display("[TB] FAIL short_counts: got strobes=%0d pkts=%0d overlap=%0d expected 100 1 0", strobes, pkts, overlap);
        end
        testsRun++;
        if (pktAt - last !== 64 || c - pktAt !== 4) begin
            testsFailed++;
            $display("[TB] FAIL short_timing: got pktend +%0d idle +%0d expected 64 4", pktAt - last, c - pktAt);
        end
    endtask

    task automatic test_enable_drop();
        int n;
        int c;
        int strobes;
        int last;
        int pktAt;
        int pkts;
        do_reset();
        enable    = 1'b1;
        ch0_valid = 1'b1;
        dma_rdy0  = 1'b1;
        wait_busy(1'b1, 10, n);
        c = 0; strobes = 0; last = -1; pktAt = -1; pkts = 0;
        while (busy === 1'b1 && c < 100) begin
            if (slwr_n === 1'b0) begin
                strobes++;
                last = c;
            end
            if (pktend_n === 1'b0) begin
                pkts++;
                pktAt = c;
            end
            tick();
            c++;
            if (idx0 >= 10) enable = 1'b0;
        end
        testsRun++;
        if (strobes !== 10 || pkts !== 1 || pktAt - last !== 1 || c - pktAt !== 4) begin
            testsFailed++;
            $display("[TB] FAIL drop_sequence: got strobes=%0d pkts=%0d pktend +%0d idle +%0d expected 10 1 1 4",
                     strobes, pkts, pktAt - last, c - pktAt);
        end
        tick();
        tick();
        testsRun++;
        if (busy !== 1'b0 || slcs_n !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL drop_stays_idle: got busy=%b slcs_n=%b expected 0 1", busy, slcs_n);
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int strobes;
        int pkts;
        int cyc;
        do_reset();
        enable    = 1'b1;
        ch0_valid = 1'b1;
        dma_rdy0  = 1'b1;
        dma_rdy1  = 1'b1;
        n = 0;
        while (idx0 < 10 && n < 50) begin
            tick();
            n++;
        end
        enable = 1'b0;
        run_until_idle(20, strobes, pkts, cyc);
        enable    = 1'b1;
        ch1_valid = 1'b1;
        wait_busy(1'b1, 10, n);
        testsRun++;
        if (busy !== 1'b1 || grant !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL rst_pre_grant: got busy=%b grant=%b expected 1 1", busy, grant);
        end
        n = 0;
        while (idx1 < 5 && n < 30) begin
            tick();
            n++;
        end
        reset = 1'b1;
        tick();
        testsRun++;
        if ({slwr_n, pktend_n, slcs_n, busy, ch0_ready, ch1_ready} !== 6'b111000) begin
            testsFailed++;
            $display("[TB] FAIL rst_mid_burst: got slwr_n=%b pktend_n=%b slcs_n=%b busy=%b rdy0=%b rdy1=%b expected 1 1 1 0 0 0",
                     slwr_n, pktend_n, slcs_n, busy, ch0_ready, ch1_ready);
        end
        reset = 1'b0;
        wait_busy(1'b1, 10, n);
        testsRun++;
        if (busy !== 1'b1 || grant !== 1'b0 || faddr !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL rst_first_tie: got busy=%b grant=%b faddr=%b expected 1 0 00", busy, grant, faddr);
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_stream_ch0();
        test_round_robin();
        test_socket_not_ready();
        test_short_packet();
        test_enable_drop();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fx3_wr_scheduler.md
# fx3_wr_scheduler

Write-side scheduler for the FX3 slave-FIFO interface. It shares the single 32-bit GPIF write port between two streaming sources (ch0 → socket address 2'b00, ch1 → 2'b01). It grants whole DMA bursts round-robin, gated by each socket's ready flag, and commits short packets with PKTEND when a source stalls or streaming is disabled. It sits between the ADC stream generators and the pad-level FX3 outputs, in the clk_100 domain.

## Interface
- BURST_LEN, 1024: words per full DMA buffer (≥2).
- ADDR_SETTLE, 3: cycles between faddr change and a valid flag sample.
- IDLE_TIMEOUT, 64: stall cycles in a burst before a short packet is forced.
- GAP_CYCLES, 3: dead cycles after each burst before the next arbitration.

- clk_100  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high.
- enable  in  1  streaming mode selected; 0 drains the block to IDLE.
- ch0_data / ch1_data  in  32  source words.
- ch0_valid / ch1_valid  in  1  source word available.
- ch0_ready / ch1_ready  out  1  word accepted this cycle when valid&ready.
- dma_rdy0 / dma_rdy1  in  1  registered FX3 socket-ready flags (1 = room for a full burst).
- faddr  out  2  FIFO address.
- fdata  out  32  write data.
- slwr_n  out  1  write strobe, active low.
- pktend_n  out  1  packet end, active low.
- slcs_n  out  1  chip select, active low. It is 0 whenever the state is not IDLE.
- grant  out  1  channel owning the port. Valid when busy=1.
- busy  out  1  state ≠ IDLE.

## Operation
- States: IDLE, ADDR, CHECK, BURST, PKTEND, GAP.
- IDLE:
  - eligible_i = enable & chi_valid.
  - If both channels are eligible, grant the channel ≠ last_grant. Otherwise grant the single eligible channel.
  - On grant: latch grant, drive faddr = {1'b0, grant}, load settle counter, go to ADDR.
- ADDR: count ADDR_SETTLE cycles, then go to CHECK.
- CHECK:
  - If dma_rdy[grant] = 1: load words_left = BURST_LEN, clear stall counter, go to BURST.
  - Otherwise go to IDLE. last_grant is not updated, so the other channel may win next.
- BURST:
  - ch[grant]_ready = 1 while words_left > 0 and enable = 1. The non-granted ready is always 0.
  - On each transfer: fdata ← data, slwr_n ← 0 on the next cycle, words_left decrements, stall counter clears.
  - No transfer in a cycle: slwr_n ← 1 and the stall counter increments.
- BURST exits:
  - words_left reaches 0: set last_grant = grant, go to GAP. No PKTEND; the full buffer auto-commits.
  - Stall counter reaches IDLE_TIMEOUT, or enable = 0:
    - If at least one word was written, go to PKTEND.
    - If zero words were written, go to GAP without PKTEND.
    - In both cases last_grant = grant.
- PKTEND: pktend_n = 0 and slwr_n = 1 for exactly one cycle, faddr held, then go to GAP.
- GAP: hold faddr, slwr_n = 1 for GAP_CYCLES, then go to IDLE.
- Status registers: words_left is log2(BURST_LEN)+1 bits and never underflows. The stall counter saturates at IDLE_TIMEOUT.
- Reset values: state = IDLE, faddr = 2'b00, fdata = 0, slwr_n = 1, pktend_n = 1, slcs_n = 1, ready = 0, busy = 0, grant = 0, last_grant = 1 (so ch0 wins the first tie).

## Timing
- All FX3-facing outputs are registered.
- fdata/slwr_n follow the accepting handshake by exactly 1 cycle.
- Grant to first possible ready = 1 + ADDR_SETTLE + 1 cycles.
- Peak throughput is 1 word/cycle. A full burst takes BURST_LEN cycles plus stalls.
- dma_rdy is sampled only in CHECK. Deassertion during BURST is ignored, because the flag guarantees room for a full buffer.
- slwr_n and pktend_n are never low in the same cycle.
- faddr changes only when leaving IDLE.
- Synchronous reset mid-burst: the next edge forces reset values. No PKTEND is emitted, and data in flight is dropped.
- When enable falls mid-ADDR or mid-CHECK: go straight to IDLE, no writes.

## Test plan
- Reset, then ch0 streams continuously with dma_rdy0 = 1:
  - faddr = 00.
  - First slwr_n low 5 cycles after the grant (defaults).
  - Exactly 1024 consecutive write strobes, no PKTEND.
  - 3-cycle gap, then the next burst.
- Both channels valid, both sockets ready:
  - Bursts alternate ch0, ch1, ch0 with faddr 00/01/00.
  - The non-granted ready stays 0 throughout.
- ch1 granted with dma_rdy1 = 0 in CHECK:
  - No slwr_n.
  - Back to IDLE, next grant goes to ch0.
  - Once dma_rdy1 = 1, ch1 is granted again.
- ch0 sends 100 words, then valid = 0 for 64 cycles:
  - 100 strobes, then one pktend_n pulse with slwr_n = 1.
  - fdata of strobe N equals the Nth accepted word.
- enable dropped after 10 words: PKTEND after the 10th strobe, then GAP → IDLE, busy = 0.
- Sync reset asserted mid-burst:
  - Next cycle: slwr_n = 1, pktend_n = 1, slcs_n = 1, ready = 0.
  - After release, ch0 wins the first tie.
